sar_sequencer: RTL
==================

SAR_SEQUENCER -- requirements
Module: sar_sequencer

Interface
REQ-001 Parameter RESOLUTION, default 8, ADC result width in bits.
REQ-002 Parameter DIV_WIDTH, default 16, sample-period counter width.
REQ-003 Parameter FIFO_DEPTH, default 4, result FIFO entries; SHALL be a power of two, at least 2.
REQ-004 clk_i  input  1  clock; all state changes on its rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 enable_i  input  1  continuous periodic conversion request.
REQ-007 single_i  input  1  one-shot conversion request, sampled in IDLE only.
REQ-008 period_i  input  DIV_WIDTH  cycles between start pulses, minus one.
REQ-009 clear_i  input  1  synchronous clear of FIFO, overflow_o and timeout_o.
REQ-010 start_o  output  1  conversion start pulse to the SAR controller.
REQ-011 adc_rdy_i  input  1  SAR ready level; a rising edge marks conversion done.
REQ-012 adc_result_i  input  RESOLUTION  SAR result, valid when adc_rdy_i is high.
REQ-013 data_o  output  RESOLUTION  FIFO head sample.
REQ-014 valid_o / ready_i  output / input  1 each  stream handshake; transfer when both are high.
REQ-015 busy_o, overflow_o, timeout_o  output  1 each  state not IDLE; sticky FIFO-drop flag; sticky no-ready flag.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT, START, CONV and STORE.
REQ-017 IDLE -> START when enable_i or single_i is high; otherwise stay in IDLE.
REQ-018 In START, start_o SHALL be high for exactly one cycle; the period timer loads period_i; next state CONV.
REQ-019 start_o SHALL never be high in any other state, so the SAR never enters restart mode.
REQ-020 CONV SHALL register adc_rdy_i and detect a 0->1 transition; on that edge, capture adc_result_i and go to STORE.
REQ-021 CONV SHALL count cycles; if no rising edge has occurred after RESOLUTION+4 cycles, set timeout_o and go to IDLE with no push.
REQ-022 STORE SHALL push the captured or averaged sample for one cycle, then:
- go to WAIT if enable_i is high;
- go to IDLE otherwise.
REQ-023 In WAIT, the timer SHALL decrement by one per cycle and go to START when it is zero; if enable_i drops, go to IDLE.
REQ-024 The start-to-start interval SHALL be max(period_i+1, conversion time + 2) cycles; the timer keeps counting during CONV.
REQ-025 Deasserting enable_i during CONV SHALL let the conversion complete and store its result.
REQ-026 FIFO write on push when not full; if full and no pop occurs in the same cycle, drop the new sample and set overflow_o.
REQ-027 If full with a simultaneous push and pop, both SHALL succeed.
REQ-028 If empty with a simultaneous push, valid_o SHALL rise the next cycle; there is no fall-through.
REQ-029 valid_o SHALL be high exactly when the FIFO is not empty; data_o SHALL hold stable while valid_o is high and ready_i is low.
REQ-030 clear_i SHALL empty the FIFO and clear the flags; a push in the same cycle is discarded.
REQ-031 Pointers SHALL be log2(FIFO_DEPTH)+1 bits wide, with wrap-around via the MSB.

Reset
REQ-032 On rst_ni low, all registers SHALL reset asynchronously:
- state IDLE;
- start_o = 0, valid_o = 0, busy_o = 0, overflow_o = 0, timeout_o = 0;
- data_o = 0, FIFO empty, timer = 0.
REQ-033 A reset asserted mid-conversion SHALL abort it; after release the block waits in IDLE for a new request.

Configuration
REQ-034 The macro SAR_SEQ_AVG_EN SHALL enable 4x averaging.
REQ-035 With SAR_SEQ_AVG_EN defined:
- STORE accumulates into a (RESOLUTION+2)-bit sum;
- it pushes only on every fourth conversion, pushing sum>>2 truncated and clearing the sum;
- single_i triggers four back-to-back conversions;
- timeout, clear_i and reset clear the sum and the count.
REQ-036 Without SAR_SEQ_AVG_EN, every conversion SHALL push its raw result and no accumulator logic SHALL exist.

Verification
REQ-037 Single shot: with SAR model RESOLUTION=8 and input 0xA5, pulse single_i -> exactly one start_o pulse, data_o=0xA5 with valid_o, return to IDLE, busy_o=0.
REQ-038 Periodic: enable_i=1, period_i=49 -> start_o pulses exactly 50 cycles apart; with period_i=0 -> interval equals conversion time + 2.
REQ-039 Overflow: ready_i=0, 5 conversions at FIFO_DEPTH=4 -> 4 entries kept, overflow_o=1, fifth sample lost; clear_i -> valid_o=0, overflow_o=0.
REQ-040 Timeout: adc_rdy_i held 0 after start_o -> timeout_o=1 at 12 cycles into CONV, state IDLE, nothing pushed.
REQ-041 Full with simultaneous push and pop: FIFO full, ready_i=1 in the push cycle -> no overflow, count stays 4, order preserved.
REQ-042 Averaging (SAR_SEQ_AVG_EN): results 10, 11, 12, 14 -> one push of 11; reset mid-conversion -> start_o=0 and IDLE immediately.

Source files
------------

// File: rtl/sar_sequencer.sv
// ---------------------------------------------------------------------------
// sar_sequencer
//
// Sequences conversions of an external SAR ADC controller. It issues start
// pulses (one-shot or periodic), waits for the ready rising edge, captures
// the result and pushes it into a small result FIFO. The FIFO is drained
// through a valid/ready stream.
//
// Optional feature: define SAR_SEQ_AVG_EN to average four conversions per
// FIFO entry. A single_i request then runs four back-to-back conversions.
//
// Ports
//   clk_i         clock, all state changes on the rising edge
//   rst_ni        asynchronous active-low reset
//   enable_i      continuous periodic conversion request
//   single_i      one-shot request, sampled in IDLE
//   period_i      start-to-start period in cycles, minus one
//   clear_i       synchronous clear of FIFO, overflow_o and timeout_o
//   start_o       one-cycle start pulse to the SAR controller
//   adc_rdy_i     SAR ready level, rising edge marks conversion done
//   adc_result_i  SAR result, valid while adc_rdy_i is high
//   data_o        FIFO head sample
//   valid_o       FIFO not empty
//   ready_i       sink accepts data_o when high together with valid_o
//   busy_o        sequencer is not IDLE
//   overflow_o    sticky: a sample was dropped because the FIFO was full
//   timeout_o     sticky: a conversion never reported ready
// ---------------------------------------------------------------------------
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no conversion pending, wait for enable_i or single_i
// START | start_o high for this single cycle, period timer loaded
// CONV  | wait for adc_rdy_i rising edge, bounded by the timeout counter
// STORE | push the captured (or averaged) sample
// WAIT  | periodic mode, wait for the period timer to expire

module sar_sequencer #(
  parameter int RESOLUTION = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic                  single_i,
  input  logic [DIV_WIDTH-1:0]  period_i,
  input  logic                  clear_i,
  output logic                  start_o,
  input  logic                  adc_rdy_i,
  input  logic [RESOLUTION-1:0] adc_result_i,
  output logic [RESOLUTION-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  busy_o,
  output logic                  overflow_o,
  output logic                  timeout_o
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int PTR_W  = AW + 1;
  localparam int CONV_W = $clog2(RESOLUTION + 4);
  // CONV lasts at most RESOLUTION+4 cycles: the counter runs LOAD..0.
  localparam logic [CONV_W-1:0] CONV_LOAD = CONV_W'(RESOLUTION + 3);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    START = 3'd2,
    CONV  = 3'd3,
    STORE = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [DIV_WIDTH-1:0]    timer_q;
  logic [CONV_W-1:0]       conv_cnt_q;
  logic                    rdy_q;
  logic                    rdy_rise;
  logic [RESOLUTION-1:0]   sample_q;
  logic                    store_slot;
  logic                    timeout_hit;
  logic                    burst_more;
  logic                    push;
  logic [RESOLUTION-1:0]   push_data;
  logic                    overflow_q;
  logic                    timeout_q;

  logic [RESOLUTION-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic                    fifo_empty, fifo_full;
  logic                    pop, wr_en, overflow_hit;

  assign rdy_rise = adc_rdy_i & ~rdy_q;

  // ---------------------------------------------------------------------
  // Optional 4x averaging
  // ---------------------------------------------------------------------
`ifdef SAR_SEQ_AVG_EN
  logic [RESOLUTION+1:0] avg_sum_q;
  logic [1:0]            avg_cnt_q;
  logic [RESOLUTION+1:0] avg_total;

  assign avg_total  = avg_sum_q + {2'b00, sample_q};
  assign push       = store_slot && (avg_cnt_q == 2'd3);
  assign push_data  = RESOLUTION'(avg_total >> 2);
  // Without enable_i a group still runs to four conversions back-to-back.
  assign burst_more = (avg_cnt_q != 2'd3);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      avg_sum_q <= '0;
      avg_cnt_q <= '0;
    end else if (clear_i || timeout_hit) begin
      avg_sum_q <= '0;
      avg_cnt_q <= '0;
    end else if (store_slot) begin
      if (avg_cnt_q == 2'd3) begin
        avg_sum_q <= '0;
        avg_cnt_q <= '0;
      end else begin
        avg_sum_q <= avg_total;
        avg_cnt_q <= avg_cnt_q + 2'd1;
      end
    end
  end
`else
  assign push       = store_slot;
  assign push_data  = sample_q;
  assign burst_more = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    store_slot  = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i || single_i) state_d = START;
      end
      START: begin
        state_d = CONV;
      end
      CONV: begin
        // A ready edge on the last allowed cycle still counts as done.
        if (rdy_rise) begin
          state_d = STORE;
        end else if (conv_cnt_q == '0) begin
          timeout_hit = 1'b1;
          state_d     = IDLE;
        end
      end
      STORE: begin
        store_slot = 1'b1;
        if (enable_i)        state_d = WAIT;
        else if (burst_more) state_d = START;
        else                 state_d = IDLE;
      end
      WAIT: begin
        // Leave when the count after this cycle's decrement is zero, so the
        // next start lands exactly period_i+1 cycles after the previous one.
        if (!enable_i)                       state_d = IDLE;
        else if (timer_q <= DIV_WIDTH'(1))   state_d = START;
      end
      default: state_d = IDLE;
    endcase
  end

  assign start_o = (state_q == START);
  assign busy_o  = (state_q != IDLE);

  // ---------------------------------------------------------------------
  // Timers, ready edge detector, sample capture
  // ---------------------------------------------------------------------
  // The period timer keeps running through CONV and STORE so a slow
  // conversion stretches the interval instead of adding to it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer_q <= '0;
    end else if (state_q == START) begin
      timer_q <= period_i;
    end else if (timer_q != '0) begin
      timer_q <= timer_q - DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      conv_cnt_q <= '0;
    end else if (state_q == START) begin
      conv_cnt_q <= CONV_LOAD;
    end else if ((state_q == CONV) && (conv_cnt_q != '0)) begin
      conv_cnt_q <= conv_cnt_q - CONV_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdy_q    <= 1'b0;
      sample_q <= '0;
    end else begin
      rdy_q <= adc_rdy_i;
      if ((state_q == CONV) && rdy_rise) sample_q <= adc_result_i;
    end
  end

  // ---------------------------------------------------------------------
  // Result FIFO
  // ---------------------------------------------------------------------
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign valid_o    = ~fifo_empty;
  assign data_o     = mem_q[rd_ptr_q[AW-1:0]];

  assign pop          = valid_o && ready_i;
  // When full, a same-cycle pop frees the head slot; the head is read out
  // this cycle before the write lands on the clock edge.
  assign wr_en        = push && !clear_i && (!fifo_full || pop);
  assign overflow_hit = push && !clear_i && fifo_full && !pop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        wr_ptr_q                <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Sticky flags
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else if (clear_i) begin
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      if (overflow_hit) overflow_q <= 1'b1;
      if (timeout_hit)  timeout_q  <= 1'b1;
    end
  end

  assign overflow_o = overflow_q;
  assign timeout_o  = timeout_q;

endmodule
